// File: rtl/opr1_link_acc.sv
// opr1_link_acc: Link+Accumulator unit executing one OPR group-1 micro-op word
// (CLA CLL CMA CML IAC RAR RAL BSW) in the standard event order.
// STAGED=1 walks CLR->CMP->INC->ROT1->ROT2, one step per clk; STAGED=0 runs the
// whole chain in a single clk. The load strobe is named force_load because
// "force" is a reserved word in SystemVerilog.
module opr1_link_acc #(
    parameter int WIDTH  = 12,
    parameter bit STAGED = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ck,
    input  logic             force_load,
    input  logic [WIDTH-1:0] load_ac,
    input  logic             load_l,
    input  logic             cla,
    input  logic             cll,
    input  logic             cma,
    input  logic             cml,
    input  logic             iac,
    input  logic             rar,
    input  logic             ral,
    input  logic             bsw,
    output logic [WIDTH-1:0] ac,
    output logic             l,
    output logic             l_preview,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_CMP, S_INC, S_ROT1, S_ROT2} state_t;

    typedef struct packed {
        logic cla, cll, cma, cml, iac, rar, ral, bsw;
    } ops_t;

    // One micro-op event applied to the {L,AC} pair.
    function automatic logic [WIDTH:0] step(input state_t st, input ops_t o,
                                            input logic [WIDTH:0] la);
        logic             lk;
        logic [WIDTH-1:0] a;
        logic             rot_r, rot_l;
        lk    = la[WIDTH];
        a     = la[WIDTH-1:0];
        // rar and ral together cancel: neither rotate nor swap
        rot_r = o.rar & ~o.ral;
        rot_l = o.ral & ~o.rar;
        case (st)
            S_CLR: begin
                if (o.cla) a  = '0;
                if (o.cll) lk = 1'b0;
            end
            S_CMP: begin
                if (o.cma) a  = ~a;
                if (o.cml) lk = ~lk;
            end
            S_INC: begin
                if (o.iac) begin
                    if (&a) lk = ~lk;   // carry out of AC toggles the link
                    a = a + 1'b1;
                end
            end
            S_ROT1, S_ROT2: begin
                // ROT2 only repeats a rotate when bsw doubles it
                if (st == S_ROT1 || o.bsw) begin
                    if (rot_r)
                        {lk, a} = {a[0], lk, a[WIDTH-1:1]};
                    else if (rot_l)
                        {lk, a} = {a, lk};
                    else if (st == S_ROT1 && o.bsw && !o.rar && !o.ral)
                        a = {a[WIDTH/2-1:0], a[WIDTH-1:WIDTH/2]};
                end
            end
            default: ;
        endcase
        return {lk, a};
    endfunction

    state_t           state_q, state_d;
    ops_t             ops_q, ops_d;
    logic [WIDTH-1:0] ac_q, ac_d;
    logic             l_q, l_d;
    logic             lprev_q, lprev_d;
    logic             done_q, done_d;
    logic             pend_q, pend_d;
    logic             overrun_q, overrun_d;
    logic             last_ck_q, last_ck_d;

    ops_t             ops_in;
    logic             start;
    logic [WIDTH:0]   la_cur, la_one;

    assign ops_in = '{cla: cla, cll: cll, cma: cma, cml: cml,
                      iac: iac, rar: rar, ral: ral, bsw: bsw};
    assign start  = ck & ~last_ck_q;
    assign la_cur = {l_q, ac_q};
    // Single-cycle path: full chain on the live op bits, used only when STAGED=0
    assign la_one = step(S_ROT2, ops_in, step(S_ROT1, ops_in, step(S_INC, ops_in,
                    step(S_CMP, ops_in, step(S_CLR, ops_in, la_cur)))));

    // Next-state, datapath and handshake logic
    always_comb begin
        state_d   = state_q;
        ops_d     = ops_q;
        {l_d, ac_d} = la_cur;
        done_d    = pend_q;        // force / single-cycle completion lags the load by one clk
        pend_d    = 1'b0;
        overrun_d = overrun_q;
        last_ck_d = ck;
        lprev_d   = (l_q & ~cll) ^ cml;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ops_d     = ops_in;
                    overrun_d = 1'b0;
                    if (force_load) begin
                        {l_d, ac_d} = {load_l, load_ac};
                        pend_d      = 1'b1;
                    end else if (STAGED) begin
                        state_d = S_CLR;
                    end else begin
                        {l_d, ac_d} = la_one;
                        pend_d      = 1'b1;
                    end
                end
            end
            default: begin
                {l_d, ac_d} = step(state_q, ops_q, la_cur);
                if (start) overrun_d = 1'b1;
                case (state_q)
                    S_CLR:   state_d = S_CMP;
                    S_CMP:   state_d = S_INC;
                    S_INC:   state_d = S_ROT1;
                    S_ROT1:  state_d = S_ROT2;
                    default: begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // Register bank with synchronous reset; last_ck resets high so a held ck is not a start
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ops_q     <= '0;
            ac_q      <= '0;
            l_q       <= 1'b0;
            lprev_q   <= 1'b0;
            done_q    <= 1'b0;
            pend_q    <= 1'b0;
            overrun_q <= 1'b0;
            last_ck_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            ops_q     <= ops_d;
            ac_q      <= ac_d;
            l_q       <= l_d;
            lprev_q   <= lprev_d;
            done_q    <= done_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
            last_ck_q <= last_ck_d;
        end
    end

    assign ac        = ac_q;
    assign l         = l_q;
    assign l_preview = lprev_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_opr1_link_acc.sv
// Directed bench for opr1_link_acc: staged and single-cycle instances share stimulus;
// expected {L,AC} results are queued at issue and popped when the staged unit reports done.
module tb_opr1_link_acc;

    localparam logic [7:0] CLA = 8'h80, CLL = 8'h40, CMA = 8'h20, CML = 8'h10;
    localparam logic [7:0] IAC = 8'h08, RAR = 8'h04, RAL = 8'h02, BSW = 8'h01;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ck = 1'b1;
    logic        force_load = 1'b0;
    logic [11:0] load_ac = '0;
    logic        load_l = 1'b0;
    logic        cla = 0, cll = 0, cma = 0, cml = 0, iac = 0, rar = 0, ral = 0, bsw = 0;

    logic [11:0] ac1, ac0;
    logic        l1, l0, lp1, lp0, busy1, busy0, done1, done0, ovr1, ovr0;

    int total = 0;
    int bad   = 0;
    logic [12:0] sb[$];

    always #5 clk = ~clk;

    opr1_link_acc #(.WIDTH(12), .STAGED(1'b1)) u_stg (
        .clk(clk), .reset(reset), .ck(ck), .force_load(force_load),
        .load_ac(load_ac), .load_l(load_l),
        .cla(cla), .cll(cll), .cma(cma), .cml(cml), .iac(iac),
        .rar(rar), .ral(ral), .bsw(bsw),
        .ac(ac1), .l(l1), .l_preview(lp1), .busy(busy1), .done(done1), .overrun(ovr1));

    opr1_link_acc #(.WIDTH(12), .STAGED(1'b0)) u_cmb (
        .clk(clk), .reset(reset), .ck(ck), .force_load(force_load),
        .load_ac(load_ac), .load_l(load_l),
        .cla(cla), .cll(cll), .cma(cma), .cml(cml), .iac(iac),
        .rar(rar), .ral(ral), .bsw(bsw),
        .ac(ac0), .l(l0), .l_preview(lp0), .busy(busy0), .done(done0), .overrun(ovr0));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
        end
    endtask

    // Issue one start and follow it to completion. ovr_at >= 0 injects a second
    // ck edge that many clks after the start.
    task automatic run(input string tag, input logic [7:0] ops, input logic frc,
                       input logic [11:0] lac, input logic ll,
                       input int exp_lat, input int exp_busy, input int ovr_at);
        logic [12:0] exp;
        int n, n0, bc;
        bit seen;
        if (sb.size() == 0) begin
            total++; bad++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
            return;
        end
        exp = sb[0];
        {cla, cll, cma, cml, iac, rar, ral, bsw} = ops;
        force_load = frc; load_ac = lac; load_l = ll;
        ck = 1'b1;
        tick();
        // scramble inputs: the captured copy must be what executes
        ck = 1'b0;
        {cla, cll, cma, cml, iac, rar, ral, bsw} = 8'h00;
        force_load = 1'b0; load_ac = ~lac; load_l = ~ll;
        n = 0; n0 = -1; bc = int'(busy1); seen = 0;
        while (!seen && n < 20) begin
            if (n == ovr_at) ck = 1'b1;
            tick();
            ck = 1'b0;
            n++;
            if (done0 && n0 < 0) begin
                n0 = n;
                chk({tag, "_cmb_res"}, {19'd0, l0, ac0}, {19'd0, exp});
            end
            if (done1) seen = 1;
            bc += int'(busy1);
        end
        chk({tag, "_done"}, {31'd0, seen}, 32'd1);
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_busy_clks"}, bc, exp_busy);
        chk({tag, "_cmb_lat"}, n0, 1);
        exp = sb.pop_front();
        chk({tag, "_res"}, {19'd0, l1, ac1}, {19'd0, exp});
        chk({tag, "_ovr"}, {31'd0, ovr1}, {31'd0, ovr_at >= 0});
        tick();
    endtask

    task automatic load(input logic [11:0] v, input logic ll);
        sb.push_back({ll, v});
        run("force", 8'h00, 1'b1, v, ll, 1, 0, -1);
    endtask

    initial begin
        int dc;
        // 1: reset with ck held high, release with ck still high
        repeat (3) tick();
        reset = 1'b0;
        dc = 0;
        repeat (3) begin tick(); dc += int'(done1) + int'(done0) + int'(busy1); end
        chk("rst_ac", {20'd0, ac1}, 32'd0);
        chk("rst_l", {31'd0, l1}, 32'd0);
        chk("rst_lprev", {31'd0, lp1}, 32'd0);
        chk("rst_ovr", {31'd0, ovr1}, 32'd0);
        chk("rst_ac_cmb", {20'd0, ac0}, 32'd0);
        chk("rst_no_start", dc, 0);
        ck = 1'b0;
        tick();

        // 2: force load
        load(12'o1234, 1'b1);
        // l_preview from live cll/cml with l=1
        cml = 1'b1; tick();
        chk("lprev_cml", {31'd0, lp1}, 32'd0);
        cml = 1'b0; cll = 1'b1; tick();
        chk("lprev_cll", {31'd0, lp1}, 32'd0);
        cll = 1'b0; tick();
        chk("lprev_hold", {31'd0, lp1}, 32'd1);

        // 3: cla cma iac cll
        load(12'o5555, 1'b0);
        sb.push_back({1'b1, 12'o0000});
        run("cla_cma_iac_cll", CLA | CMA | IAC | CLL, 1'b0, 12'o0, 1'b0, 5, 5, -1);

        // 4: ral+bsw rotate two left
        load(12'o4001, 1'b1);
        sb.push_back({1'b0, 12'o0007});
        run("ral_bsw", RAL | BSW, 1'b0, 12'o0, 1'b0, 5, 5, -1);

        // 5: byte swap, then rar+ral cancel
        load(12'o1234, 1'b1);
        sb.push_back({1'b1, 12'o3412});
        run("bsw", BSW, 1'b0, 12'o0, 1'b0, 5, 5, -1);
        sb.push_back({1'b1, 12'o3412});
        run("rar_ral", RAR | RAL, 1'b0, 12'o0, 1'b0, 5, 5, -1);

        // extra: IAC carry into link, rotate-two right
        load(12'o7777, 1'b0);
        sb.push_back({1'b1, 12'o0000});
        run("iac_carry", IAC, 1'b0, 12'o0, 1'b0, 5, 5, -1);
        load(12'o0001, 1'b0);
        sb.push_back({1'b0, 12'o4000});
        run("rar_bsw", RAR | BSW, 1'b0, 12'o0, 1'b0, 5, 5, -1);

        // 6: second edge while busy sets overrun, first result intact
        load(12'o1234, 1'b1);
        sb.push_back({1'b1, 12'o6543});
        run("cma_ovr", CMA, 1'b0, 12'o0, 1'b0, 5, 5, 2);
        // accepted start clears overrun (checked inside run)
        load(12'o1111, 1'b0);

        // 6: reset asserted while in ROT1 aborts with no done
        cma = 1'b1; ck = 1'b1; tick();
        cma = 1'b0; ck = 1'b0;
        repeat (3) tick();
        chk("abort_busy_pre", {31'd0, busy1}, 32'd1);
        reset = 1'b1;
        tick();
        chk("abort_ac", {20'd0, ac1}, 32'd0);
        chk("abort_l", {31'd0, l1}, 32'd0);
        chk("abort_busy", {31'd0, busy1}, 32'd0);
        reset = 1'b0;
        dc = int'(done1);
        repeat (8) begin tick(); dc += int'(done1); end
        chk("abort_no_done", dc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
